// File: rtl/router_pkg.sv
// Shared constants and elaboration helpers for the router synchroniser.
package router_pkg;

   localparam int NUM_PORTS_DEF = 3;
   localparam int TIMEOUT_DEF   = 30;

   // Ceiling log2 that can be evaluated while parameters are being elaborated.
   function automatic int clog2(input int value);
      int result;
      int remain;
      result = 0;
      remain = value - 1;
      while (remain > 0) begin
         result++;
         remain = remain >>> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/router_sync_wdog.sv
// Per-port stall watchdog: flushes a FIFO the destination has stopped draining.
module router_sync_wdog
   import router_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF,
   parameter int CNT_W   = 5
) (
   input  logic clock,
   input  logic resetn,
   input  logic stall,
   input  logic clr,
   output logic soft_reset,
   output logic tout_sts
);

   logic [CNT_W-1:0] cnt;
   logic             expire;

   assign expire = stall && (cnt == CNT_W'(TIMEOUT - 1));

   // NOTE: non-blocking assignments keep every register reading pre-edge values, so ordering inside the block cannot change behaviour.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         cnt        <= '0;
         soft_reset <= 1'b0;
         tout_sts   <= 1'b0;
      end else begin
         soft_reset <= expire;
         if (!stall || expire) cnt <= '0;
         else                  cnt <= cnt + CNT_W'(1);
         // A timeout in the same cycle as a clear must not be lost.
         if (expire)   tout_sts <= 1'b1;
         else if (clr) tout_sts <= 1'b0;
      end
   end

endmodule

// File: rtl/router_sync_param.sv
// Address latch, write-enable decode, full-flag mux and per-port watchdogs
// between the router FSM and its output FIFOs.
module router_sync_param
   import router_pkg::*;
#(
   parameter int NUM_PORTS = NUM_PORTS_DEF,
   parameter int ADDR_W    = 2,
   parameter int TIMEOUT   = TIMEOUT_DEF,
   parameter int CNT_W     = 5
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 detect_add,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 write_enb_reg,
   input  logic [NUM_PORTS-1:0] read_enb,
   input  logic [NUM_PORTS-1:0] empty,
   input  logic [NUM_PORTS-1:0] full,
   input  logic [NUM_PORTS-1:0] tout_clr,
   output logic [NUM_PORTS-1:0] vld_out,
   output logic [NUM_PORTS-1:0] write_enb,
   output logic                 fifo_full,
   output logic [NUM_PORTS-1:0] soft_reset,
   output logic                 addr_err,
   output logic [NUM_PORTS-1:0] tout_sts
);

   localparam bit PARAMS_OK = (NUM_PORTS >= 2) && (NUM_PORTS <= 16) &&
                              (ADDR_W >= clog2(NUM_PORTS)) &&
                              (TIMEOUT >= 2) && (TIMEOUT < 2**CNT_W);

   generate
      if (!PARAMS_OK) begin : g_bad_params
         $error("router_sync_param: inconsistent NUM_PORTS/ADDR_W/TIMEOUT/CNT_W");
      end
   endgenerate

   logic [ADDR_W-1:0] addr_q;
   logic              addr_vld;
   logic              addr_ok;

   assign addr_ok = (32'(data_in) < 32'(NUM_PORTS));

   always_ff @(posedge clock) begin
      if (!resetn) begin
         addr_q   <= '0;
         addr_vld <= 1'b0;
         addr_err <= 1'b0;
      end else begin
         addr_err <= detect_add && !addr_ok;
         if (detect_add) begin
            addr_q   <= data_in;
            addr_vld <= addr_ok;
         end
      end
   end

   assign vld_out = ~empty;

   // An invalid latched address decodes to nothing, so it never blocks the FSM.
   // NOTE: both outputs get a default before the loop; without it the comb block would infer latches.
   always_comb begin
      write_enb = '0;
      fifo_full = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (addr_vld && (addr_q == ADDR_W'(i))) begin
            write_enb[i] = write_enb_reg;
            fifo_full    = full[i];
         end
      end
   end

   generate
      for (genvar g = 0; g < NUM_PORTS; g++) begin : g_wdog
         router_sync_wdog #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
         ) u_wdog (
            .clock      (clock),
            .resetn     (resetn),
            .stall      (vld_out[g] && !read_enb[g]),
            .clr        (tout_clr[g]),
            .soft_reset (soft_reset[g]),
            .tout_sts   (tout_sts[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_router_sync_param.sv
// Self-checking bench for router_sync_param: inline checks per scenario plus a
// scoreboard of expected soft_reset pulses (port mask and cycle).
module tb_router_sync_param;

   localparam int NP = 3;
   localparam int TO = 30;

   logic          clock;
   logic          resetn;
   logic          detect_add;
   logic [1:0]    data_in;
   logic          write_enb_reg;
   logic [NP-1:0] read_enb;
   logic [NP-1:0] empty;
   logic [NP-1:0] full;
   logic [NP-1:0] tout_clr;
   logic [NP-1:0] vld_out;
   logic [NP-1:0] write_enb;
   logic          fifo_full;
   logic [NP-1:0] soft_reset;
   logic          addr_err;
   logic [NP-1:0] tout_sts;

   typedef struct {
      logic [NP-1:0] mask;
      int            cyc;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   mon_en = 0;

   router_sync_param dut (
      .clock         (clock),
      .resetn        (resetn),
      .detect_add    (detect_add),
      .data_in       (data_in),
      .write_enb_reg (write_enb_reg),
      .read_enb      (read_enb),
      .empty         (empty),
      .full          (full),
      .tout_clr      (tout_clr),
      .vld_out       (vld_out),
      .write_enb     (write_enb),
      .fifo_full     (fifo_full),
      .soft_reset    (soft_reset),
      .addr_err      (addr_err),
      .tout_sts      (tout_sts)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   // Every soft_reset pulse must match the oldest outstanding expectation.
   always @(negedge clock) begin
      if (mon_en && soft_reset !== '0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL soft_reset_unexpected: got %b at cycle %0d, expected no pulse", soft_reset, cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (soft_reset !== e.mask || cyc != e.cyc) begin
               errors++;
               $display("FAIL soft_reset_pulse: got %b at cycle %0d, expected %b at cycle %0d",
                        soft_reset, cyc, e.mask, e.cyc);
            end
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drain_check(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending: %0d expected pulse(s) never seen, first due at cycle %0d",
                  name, exp_q.size(), exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      tick(2);
      resetn = 1'b1;
      write_enb_reg = 1'b1;
      full = '1;
      #1;
      checks++;
      if (soft_reset !== 3'b000 || addr_err !== 1'b0 || tout_sts !== 3'b000) begin
         errors++;
         $display("FAIL reset_regs: soft_reset=%b addr_err=%b tout_sts=%b, expected 000 0 000",
                  soft_reset, addr_err, tout_sts);
      end
      checks++;
      if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_addr_vld: write_enb=%b fifo_full=%b, expected 000 0", write_enb, fifo_full);
      end
      write_enb_reg = 1'b0;
      full = '0;
      mon_en = 1;
   endtask

   task automatic test_addr_latch();
      empty = 3'b010;
      #1;
      checks++;
      if (vld_out !== 3'b101) begin
         errors++;
         $display("FAIL vld_out: got %b expected 101", vld_out);
      end
      empty = '1;
      detect_add = 1'b1;
      data_in = 2'd1;
      tick();
      detect_add = 1'b0;
      write_enb_reg = 1'b1;
      full = 3'b010;
      #1;
      checks++;
      if (write_enb !== 3'b010 || fifo_full !== 1'b1 || addr_err !== 1'b0) begin
         errors++;
         $display("FAIL addr1_decode: write_enb=%b fifo_full=%b addr_err=%b, expected 010 1 0",
                  write_enb, fifo_full, addr_err);
      end
      full = 3'b101;
      #1;
      checks++;
      if (fifo_full !== 1'b0) begin
         errors++;
         $display("FAIL addr1_full_mux: fifo_full=%b expected 0", fifo_full);
      end
      // New destination strobed together with a write: old address still steers.
      detect_add = 1'b1;
      data_in = 2'd2;
      #1;
      checks++;
      if (write_enb !== 3'b010) begin
         errors++;
         $display("FAIL old_addr_write: write_enb=%b expected 010", write_enb);
      end
      tick();
      detect_add = 1'b0;
      #1;
      checks++;
      if (write_enb !== 3'b100 || fifo_full !== 1'b1) begin
         errors++;
         $display("FAIL addr2_decode: write_enb=%b fifo_full=%b, expected 100 1", write_enb, fifo_full);
      end
      write_enb_reg = 1'b0;
      #1;
      checks++;
      if (write_enb !== 3'b000) begin
         errors++;
         $display("FAIL write_enb_idle: write_enb=%b expected 000", write_enb);
      end
      full = '0;
   endtask

   task automatic test_invalid_addr();
      detect_add = 1'b1;
      data_in = 2'd3;
      tick();
      detect_add = 1'b0;
      write_enb_reg = 1'b1;
      full = '1;
      #1;
      checks++;
      if (addr_err !== 1'b1) begin
         errors++;
         $display("FAIL addr_err_pulse: addr_err=%b expected 1", addr_err);
      end
      checks++;
      if (write_enb !== 3'b000 || fifo_full !== 1'b0) begin
         errors++;
         $display("FAIL invalid_decode: write_enb=%b fifo_full=%b, expected 000 0", write_enb, fifo_full);
      end
      tick();
      checks++;
      if (addr_err !== 1'b0) begin
         errors++;
         $display("FAIL addr_err_width: addr_err=%b expected 0", addr_err);
      end
      write_enb_reg = 1'b0;
      full = '0;
      // Restore a valid latched address for the tests that follow.
      detect_add = 1'b1;
      data_in = 2'd0;
      tick();
      detect_add = 1'b0;
   endtask

   task automatic test_timeout();
      int c0;
      empty = 3'b110;
      read_enb = '0;
      c0 = cyc;
      exp_q.push_back('{mask: 3'b001, cyc: c0 + TO});
      exp_q.push_back('{mask: 3'b001, cyc: c0 + 2 * TO});
      tick(TO - 1);
      checks++;
      if (tout_sts !== 3'b000) begin
         errors++;
         $display("FAIL tout_early: tout_sts=%b expected 000", tout_sts);
      end
      tick();
      checks++;
      if (tout_sts !== 3'b001) begin
         errors++;
         $display("FAIL tout_set: tout_sts=%b expected 001", tout_sts);
      end
      tick(TO);
      empty = '1;
      tick();
      drain_check("timeout");
      tout_clr = 3'b001;
      tick();
      tout_clr = '0;
      checks++;
      if (tout_sts !== 3'b000) begin
         errors++;
         $display("FAIL tout_clear: tout_sts=%b expected 000", tout_sts);
      end
   endtask

   task automatic test_restart();
      empty = 3'b110;
      read_enb = '0;
      tick(TO - 1);
      read_enb = 3'b001;
      tick();
      read_enb = '0;
      tick(TO - 1);
      empty = '1;
      tick(2);
      drain_check("restart");
      checks++;
      if (tout_sts !== 3'b000) begin
         errors++;
         $display("FAIL restart_sts: tout_sts=%b expected 000", tout_sts);
      end
   endtask

   task automatic test_multi_port();
      int c0;
      empty = 3'b010;
      read_enb = '0;
      c0 = cyc;
      exp_q.push_back('{mask: 3'b101, cyc: c0 + TO});
      tick(TO - 1);
      tout_clr = 3'b101;
      tick();
      tout_clr = '0;
      empty = '1;
      checks++;
      if (tout_sts !== 3'b101) begin
         errors++;
         $display("FAIL set_wins: tout_sts=%b expected 101", tout_sts);
      end
      tout_clr = 3'b100;
      tick();
      tout_clr = '0;
      checks++;
      if (tout_sts !== 3'b001) begin
         errors++;
         $display("FAIL clr_port2: tout_sts=%b expected 001", tout_sts);
      end
      tick(2);
      drain_check("multi_port");
   endtask

   task automatic test_reset_mid();
      int r;
      empty = 3'b110;
      read_enb = '0;
      tick(20);
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      write_enb_reg = 1'b1;
      full = '1;
      r = cyc;
      #1;
      checks++;
      if (tout_sts !== 3'b000 || soft_reset !== 3'b000 || addr_err !== 1'b0 ||
          write_enb !== 3'b000 || fifo_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: tout_sts=%b soft_reset=%b addr_err=%b write_enb=%b fifo_full=%b, expected 000 000 0 000 0",
                  tout_sts, soft_reset, addr_err, write_enb, fifo_full);
      end
      write_enb_reg = 1'b0;
      full = '0;
      exp_q.push_back('{mask: 3'b001, cyc: r + TO});
      tick(TO);
      empty = '1;
      tick(2);
      drain_check("reset_mid");
      checks++;
      if (tout_sts !== 3'b001) begin
         errors++;
         $display("FAIL reset_mid_sts: tout_sts=%b expected 001", tout_sts);
      end
   endtask

   initial begin
      resetn = 1'b0;
      detect_add = 1'b0;
      data_in = '0;
      write_enb_reg = 1'b0;
      read_enb = '0;
      empty = '1;
      full = '0;
      tout_clr = '0;
      tick();
      test_reset();
      test_addr_latch();
      test_invalid_addr();
      test_timeout();
      test_restart();
      test_multi_port();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
